// File: rtl/exu_div_pkg.sv
// Shared encodings and constants for the EXU iterative divider.
// Holds the funct3 op codes, FSM states and the RV32M special-result constants.
package exu_div_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUOT = {DIV_XLEN{1'b1}};
  localparam logic [DIV_XLEN-1:0] INT_MIN       = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/exu_div.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU): XLEN+1 cycles start-to-ready, 1 cycle for
// divide-by-zero/overflow. Control holds start_i for the whole op; dropping it in CALC aborts.
module exu_div
  import exu_div_pkg::*;
#(
  parameter int XLEN           = DIV_XLEN,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [XLEN-1:0]           dividend_i,
  input  logic [XLEN-1:0]           divisor_i,
  input  logic [2:0]                op_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
  output logic                      busy_o,
  output logic                      ready_o,
  output logic [XLEN-1:0]           result_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]         rq_q, rq_d;
  logic [XLEN-1:0]           dvsr_q, dvsr_d;
  logic                      is_rem_q, is_rem_d;
  logic                      q_neg_q, q_neg_d;
  logic                      r_neg_q, r_neg_d;
  logic [REG_ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;
  logic [XLEN-1:0]           result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  logic in_signed, in_rem, a_neg, b_neg, div_zero, ovf;

  assign in_signed = (op_i == OP_DIV) || (op_i == OP_REM);
  assign in_rem    = (op_i == OP_REM) || (op_i == OP_REMU);
  assign a_neg     = in_signed && dividend_i[XLEN-1];
  assign b_neg     = in_signed && divisor_i[XLEN-1];
  assign div_zero  = (divisor_i == '0);
  assign ovf       = in_signed && (dividend_i == XLEN'(INT_MIN)) && (divisor_i == {XLEN{1'b1}});

  // Trial subtract needs XLEN+1 bits: the bit shifted out of the upper half is significant.
  logic [XLEN:0]     trial;
  logic [XLEN:0]     trial_diff;
  logic [2*XLEN-1:0] step_rq;

  always_comb begin
    trial      = rq_q[2*XLEN-1:XLEN-1];
    trial_diff = trial - {1'b0, dvsr_q};
    step_rq    = {rq_q[2*XLEN-2:0], 1'b0};
    if (trial >= {1'b0, dvsr_q}) begin
      step_rq[2*XLEN-1:XLEN] = trial_diff[XLEN-1:0];
      step_rq[0]             = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    dvsr_d   = dvsr_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    tag_d    = tag_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    result_d = result_q;
    waddr_d  = waddr_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          tag_d    = reg_waddr_i;
          is_rem_d = in_rem;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          if (div_zero || ovf) begin
            state_d = DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            waddr_d = reg_waddr_i;
            if (div_zero) result_d = in_rem ? dividend_i : XLEN'(DIV_ZERO_QUOT);
            else          result_d = in_rem ? '0 : XLEN'(INT_MIN);
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            rq_d    = {{XLEN{1'b0}}, neg_if(a_neg, dividend_i)};
            dvsr_d  = neg_if(b_neg, divisor_i);
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      CALC: begin
        if (!start_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rq_d  = step_rq;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            waddr_d  = tag_q;
            result_d = is_rem_q ? neg_if(r_neg_q, step_rq[2*XLEN-1:XLEN])
                                : neg_if(q_neg_q, step_rq[XLEN-1:0]);
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rq_q     <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      tag_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      dvsr_q   <= dvsr_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      tag_q    <= tag_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign result_o    = result_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_exu_div.sv
// Directed bench for exu_div: latency, RV32M results, special cases, abort, reset, back-to-back.
module tb_exu_div;
  import exu_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [2:0]  op_i;
  logic [4:0]  reg_waddr_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int fails  = 0;

  exu_div #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .op_i        (op_i),
    .reg_waddr_i (reg_waddr_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .reg_waddr_o (reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = tag;
  endtask

  // Counts negedges after the accepting edge until ready_o is seen (bounded).
  task automatic wait_ready(output int n, output int bn);
    n  = 0;
    bn = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy_o === 1'b1) bn++;
    end while (ready_o !== 1'b1 && n < 40);
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                       input int lat, input int exp_busy);
    int n, bn;
    @(negedge clk);
    drive(op, a, b, tag);
    wait_ready(n, bn);
    start_i = 1'b0;
    chk({name, "_lat"}, n, lat);
    chk({name, "_busy"}, bn, exp_busy);
    chk({name, "_res"}, result_o, exp);
    chk({name, "_tag"}, {27'd0, reg_waddr_o}, {27'd0, tag});
    @(negedge clk);
    chk({name, "_pulse"}, {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    int n, bn, rdy_seen;
    rst         = 1'b1;
    start_i     = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    op_i        = OP_DIVU;
    reg_waddr_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy_o},  32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_res",   result_o,         32'd0);
    chk("rst_tag",   {27'd0, reg_waddr_o}, 32'd0);
    rst = 1'b0;

    do_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33, 32);
    do_op("remu_100_7",   OP_REMU, 32'd100,        32'd7,          5'd6,  32'd2,          33, 32);
    do_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33, 32);
    do_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  33, 32);
    do_op("div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  33, 32);
    do_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1,          33, 32);
    do_op("div_5_0",      OP_DIV,  32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1,  0);
    do_op("remu_5_0",     OP_REMU, 32'd5,          32'd0,          5'd12, 32'd5,          1,  0);
    do_op("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  1,  0);
    do_op("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1,  0);
    do_op("divu_min_m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          33, 32);
    do_op("divu_big",     OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  5'd16, 32'd1,          33, 32);
    do_op("remu_big",     OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  5'd17, 32'h7FFF_FFFE,  33, 32);

    // Operands changing under a held start must not disturb the op in flight.
    @(negedge clk);
    drive(OP_DIVU, 32'd1000, 32'd10, 5'd18);
    repeat (5) @(negedge clk);
    dividend_i  = 32'd7;
    divisor_i   = 32'd0;
    op_i        = OP_REM;
    reg_waddr_i = 5'd3;
    wait_ready(n, bn);
    start_i = 1'b0;
    chk("hold_lat", n + 5, 33);
    chk("hold_res", result_o, 32'd100);
    chk("hold_tag", {27'd0, reg_waddr_o}, 32'd18);
    @(negedge clk);

    // Abort at CALC cycle 10.
    rdy_seen = 0;
    @(negedge clk);
    drive(OP_DIVU, 32'd50, 32'd5, 5'd19);
    repeat (11) begin
      @(negedge clk);
      if (ready_o === 1'b1) rdy_seen++;
    end
    chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", {31'd0, busy_o}, 32'd0);
    repeat (40) begin
      if (ready_o === 1'b1) rdy_seen++;
      @(negedge clk);
    end
    chk("abort_no_ready", rdy_seen, 0);
    chk("abort_res_kept", result_o, 32'd100);
    chk("abort_tag_kept", {27'd0, reg_waddr_o}, 32'd18);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33, 32);

    // Reset at CALC cycle 20.
    @(negedge clk);
    drive(OP_DIVU, 32'd100, 32'd7, 5'd5);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",  {31'd0, busy_o},  32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd0);
    chk("midrst_res",   result_o,         32'd0);
    chk("midrst_tag",   {27'd0, reg_waddr_o}, 32'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("postrst_busy", {31'd0, busy_o}, 32'd0);

    // Back-to-back: start held into DONE with new operands.
    drive(OP_DIVU, 32'd10, 32'd3, 5'd1);
    wait_ready(n, bn);
    chk("b2b1_lat", n, 33);
    chk("b2b1_res", result_o, 32'd3);
    chk("b2b1_tag", {27'd0, reg_waddr_o}, 32'd1);
    dividend_i  = 32'd20;
    divisor_i   = 32'd4;
    reg_waddr_i = 5'd2;
    wait_ready(n, bn);
    start_i = 1'b0;
    chk("b2b2_lat",  n, 33);
    chk("b2b2_busy", bn, 32);
    chk("b2b2_res",  result_o, 32'd5);
    chk("b2b2_tag",  {27'd0, reg_waddr_o}, 32'd2);
    @(negedge clk);
    chk("b2b2_pulse", {31'd0, ready_o}, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
